imem_loader: RTL and testbench

Program loader for the instruction memory: the write-side counterpart of the 1024×32 asynchronous-read instruction store. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues one write per word at consecutive word addresses starting at 0. While loading, it holds the core in reset so no fetch sees a partially written program.

---
 rtl/imem_loader.sv | 110 +++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory from address 0.
// Latency: four accepted bytes then one WRITE cycle per word; io_done rises on the edge after the final write.
// Backpressure: io_in_ready is high only while collecting bytes. Define LOADER_CHECKSUM_EN to enable the running word sum.
module imem_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_start,
  input  logic [10:0] io_count,
  input  logic        io_in_valid,
  input  logic [7:0]  io_in_bits,
  output logic        io_in_ready,
  output logic        io_wen,
  output logic [9:0]  io_waddr,
  output logic [31:0] io_wdata,
  output logic        io_busy,
  output logic        io_done,
  output logic        io_core_reset,
  output logic [31:0] io_checksum
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] count;
  logic [9:0]  idx;
  logic [1:0]  byte_cnt;
  logic [31:0] word;

  logic        start_ok;
  logic        accept;
  logic        last_word;
  logic [10:0] count_sat;

  // A start is only honoured when no load is in flight.
  assign start_ok  = io_start && ((state == IDLE) || (state == DONE));
  // Saturate so the word index can never wrap past address 1023.
  assign count_sat = (io_count > 11'd1024) ? 11'd1024 : io_count;
  assign accept    = io_in_valid && (state == RECV);
  assign last_word = ({1'b0, idx} == (count - 11'd1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (io_start) state_nxt = (count_sat == 11'd0) ? DONE : RECV;
      end
      RECV: begin
        if (accept && (byte_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = last_word ? DONE : RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Count latch, byte lane assembly and word index advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= 11'd0;
      idx      <= 10'd0;
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else begin
      if (start_ok) begin
        count    <= count_sat;
        idx      <= 10'd0;
        byte_cnt <= 2'd0;
      end
      if (accept) begin
        word[{byte_cnt, 3'b000} +: 8] <= io_in_bits;
        byte_cnt                      <= byte_cnt + 2'd1;
      end
      if ((state == WRITE) && !last_word) idx <= idx + 10'd1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;

  // Running modulo-2^32 sum of every word written in the current load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                checksum <= 32'd0;
    else if (start_ok)        checksum <= 32'd0;
    else if (state == WRITE)  checksum <= checksum + word;
  end

  assign io_checksum = checksum;
`else
  assign io_checksum = 32'd0;
`endif

  // Outputs decode from the state register and datapath registers only.
  assign io_in_ready   = (state == RECV);
  assign io_wen        = (state == WRITE);
  assign io_waddr      = idx;
  assign io_wdata      = word;
  assign io_busy       = (state == RECV) || (state == WRITE);
  assign io_done       = (state == DONE);
  assign io_core_reset = io_busy;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scoreboard of expected writes fed by a byte-level reference model.
// Stimulus process drives loads; a negedge monitor pops and compares every io_wen pulse.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_start = 1'b0;
  logic [10:0] io_count = 11'd0;
  logic        io_in_valid = 1'b0;
  logic [7:0]  io_in_bits = 8'd0;
  logic        io_in_ready;
  logic        io_wen;
  logic [9:0]  io_waddr;
  logic [31:0] io_wdata;
  logic        io_busy;
  logic        io_done;
  logic        io_core_reset;
  logic [31:0] io_checksum;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  imem_loader dut (
    .clk(clk), .reset(reset), .io_start(io_start), .io_count(io_count),
    .io_in_valid(io_in_valid), .io_in_bits(io_in_bits), .io_in_ready(io_in_ready),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_busy(io_busy),
    .io_done(io_done), .io_core_reset(io_core_reset), .io_checksum(io_checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] bq[$];
  int         wen_cnt = 0;
  int         last_waddr = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: got timeout, required the event within budget (cycle %0d)", name, cyc);
  endtask

  task automatic fill_rand(input int nbytes);
    bq.delete();
    for (int i = 0; i < nbytes; i++) bq.push_back(8'($urandom_range(0, 255)));
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && io_wen) begin
      wen_cnt++;
      last_waddr = int'(io_waddr);
      check("in_ready low in WRITE", {31'd0, io_in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected write: got addr %0d data 0x%08h, required no write", io_waddr, io_wdata);
      end else begin
        e = exp_q.pop_front();
        check("waddr", {22'd0, io_waddr}, {22'd0, e.addr});
        check("wdata", io_wdata, e.data);
      end
    end
  end

  // One load: model expected writes from bq, pulse start, feed bytes, then check completion.
  task automatic do_load(input int cnt, input bit toggle, input int abort_at,
                         input bit poke_start, input bit check_lat);
    int          n;
    int          nw;
    int          c0;
    int          wen0;
    bit          ok;
    logic [31:0] w;
    logic [31:0] sum;
    wr_t         e;
    n    = (cnt > 1024) ? 1024 : cnt;
    nw   = (abort_at < 0) ? n : abort_at / 4;
    c0   = -1;
    wen0 = wen_cnt;
    sum  = 32'd0;
    for (int k = 0; k < nw; k++) begin
      w = 32'(bq[4*k]) + 32'(bq[4*k+1]) * 32'd256 + 32'(bq[4*k+2]) * 32'd65536
        + 32'(bq[4*k+3]) * 32'd16777216;
      e.addr = 10'(k);
      e.data = w;
      exp_q.push_back(e);
      sum = sum + w;
    end

    // Start with a junk byte offered in the same cycle; it must not be consumed.
    @(posedge clk); #1;
    io_start = 1'b1; io_count = cnt[10:0]; io_in_valid = 1'b1; io_in_bits = 8'hEE;
    @(posedge clk); #1;
    io_start = 1'b0; io_in_valid = 1'b0;
    check("checksum cleared by start", io_checksum, 32'd0);
    if (n == 0) begin
      check("zero count done", {31'd0, io_done}, 32'd1);
      check("zero count busy", {31'd0, io_busy}, 32'd0);
    end else begin
      check("busy after start", {31'd0, io_busy}, 32'd1);
      check("done cleared by start", {31'd0, io_done}, 32'd0);
    end

    for (int i = 0; i < 4*n; i++) begin
      if (abort_at >= 0 && i == abort_at) break;
      if (toggle) begin
        io_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      io_in_valid = 1'b1;
      io_in_bits  = bq[i];
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (io_in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        fail("byte accept");
        io_in_valid = 1'b0;
        return;
      end
      if (c0 < 0) c0 = cyc;
      if (i % 4 == 0) check("core_reset during load", {31'd0, io_core_reset}, 32'd1);
      @(posedge clk); #1;
      io_start = poke_start && (i == 1);
      io_count = 11'd1;
    end
    io_in_valid = 1'b0;
    io_start    = 1'b0;

    if (abort_at >= 0) begin
      reset = 1'b1;
      #1;
      check("abort in_ready", {31'd0, io_in_ready}, 32'd0);
      check("abort wen", {31'd0, io_wen}, 32'd0);
      check("abort busy", {31'd0, io_busy}, 32'd0);
      check("abort done", {31'd0, io_done}, 32'd0);
      check("abort core_reset", {31'd0, io_core_reset}, 32'd0);
      check("abort waddr", {22'd0, io_waddr}, 32'd0);
      check("abort wdata", io_wdata, 32'd0);
      check("abort checksum", io_checksum, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("writes before abort", 32'(wen_cnt - wen0), 32'(nw));
      return;
    end

    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (io_done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail("done wait");
      return;
    end
    if (check_lat) check("done latency", 32'(cyc - c0), 32'd10);
    check("busy low in DONE", {31'd0, io_busy}, 32'd0);
    check("core_reset low in DONE", {31'd0, io_core_reset}, 32'd0);
    check("write count", 32'(wen_cnt - wen0), 32'(n));
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    check("checksum in DONE", io_checksum, CK ? sum : 32'd0);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {31'd0, io_in_ready}, 32'd0);
    check("reset wen", {31'd0, io_wen}, 32'd0);
    check("reset busy", {31'd0, io_busy}, 32'd0);
    check("reset done", {31'd0, io_done}, 32'd0);
    check("reset core_reset", {31'd0, io_core_reset}, 32'd0);
    check("reset waddr", {22'd0, io_waddr}, 32'd0);
    check("reset wdata", io_wdata, 32'd0);
    check("reset checksum", io_checksum, 32'd0);
    reset = 1'b0;

    // Zero-word load straight from IDLE.
    bq.delete();
    do_load(0, 1'b0, -1, 1'b0, 1'b0);

    // Reference two-word stream, continuous then gapped.
    bq = {8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h34, 8'h56};
    do_load(2, 1'b0, -1, 1'b0, 1'b1);
    do_load(2, 1'b1, -1, 1'b0, 1'b0);

    // Reset after 6 bytes of a 4-word load, then reload from address 0 with a stray start mid-load.
    fill_rand(16);
    do_load(4, 1'b0, 6, 1'b0, 1'b0);
    fill_rand(12);
    do_load(3, 1'b0, -1, 1'b1, 1'b0);

    // Checksum wrap: 0xFFFFFFFF + 2.
    bq = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    do_load(2, 1'b0, -1, 1'b0, 1'b0);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(1, 9);
      fill_rand(4 * cnt);
      do_load(cnt, 1'($urandom_range(0, 1)), -1, 1'b0, 1'b0);
    end

    // Oversized count saturates at 1024 words.
    fill_rand(4096);
    do_load(2047, 1'b0, -1, 1'b0, 1'b0);
    check("last waddr", 32'(last_waddr), 32'd1023);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
